// File: rtl/painterengine_gpu_pkg.sv
// Shared types and arithmetic for the GPU blend pipe.
// Holds the blend-mode enum, channel-order constants and the normalised multiply.
package painterengine_gpu_pkg;

    typedef enum logic [1:0] {
        BLEND_OVER     = 2'd0,
        BLEND_MULTIPLY = 2'd1,
        BLEND_ADD      = 2'd2,
        BLEND_COPY     = 2'd3
    } blend_mode_t;

    localparam logic BLENDER_ARGB_MODE_XXXA = 1'b0;
    localparam logic BLENDER_ARGB_MODE_AXXX = 1'b1;

    // round(x*y/(2^cw-1)) without a divider; exact for cw = 8.
    // 32-bit intermediate covers the 2*cw+1 bits needed for cw <= 15.
    function automatic logic [31:0] mul_norm(
        input logic [31:0] x,
        input logic [31:0] y,
        input int          cw
    );
        logic [31:0] t;
        t = x * y + (32'd1 << (cw - 1));
        return (t + (t >> cw)) >> cw;
    endfunction

endpackage

// File: rtl/painterengine_gpu_blend_pipe_if.sv
// Pixel stream bundle: source/destination inputs, per-pixel controls, output.
// master = stream producer/consumer side, slave = blend pipe side.
interface painterengine_gpu_blend_pipe_if #(
    parameter int CW = 8
);
    localparam int PW = 4 * CW;

    logic          i_wire_argb_mode;
    logic [1:0]    i_wire_mode;
    logic [PW-1:0] i_wire_blend;
    logic [PW-1:0] i_wire_data1_in;
    logic          i_wire_valid1;
    logic          o_wire_ready1;
    logic [PW-1:0] i_wire_data2_in;
    logic          i_wire_valid2;
    logic          o_wire_ready2;
    logic [PW-1:0] o_wire_data_out;
    logic          o_wire_data_valid;
    logic          i_wire_out_ready;

    modport master (
        output i_wire_argb_mode, i_wire_mode, i_wire_blend,
        output i_wire_data1_in, i_wire_valid1,
        output i_wire_data2_in, i_wire_valid2,
        output i_wire_out_ready,
        input  o_wire_ready1, o_wire_ready2,
        input  o_wire_data_out, o_wire_data_valid
    );

    modport slave (
        input  i_wire_argb_mode, i_wire_mode, i_wire_blend,
        input  i_wire_data1_in, i_wire_valid1,
        input  i_wire_data2_in, i_wire_valid2,
        input  i_wire_out_ready,
        output o_wire_ready1, o_wire_ready2,
        output o_wire_data_out, o_wire_data_valid
    );

endinterface

// File: rtl/painterengine_gpu_blend_lane.sv
// One colour channel: stage-2 mode arithmetic register and stage-3 saturation.
// Ports: clock/reset, stage enable, mode, c1' / sa / c2 in, saturated channel out.
module painterengine_gpu_blend_lane
    import painterengine_gpu_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          i_wire_clock,
    input  logic          i_wire_resetn,
    input  logic          i_wire_en,
    input  blend_mode_t   i_wire_mode,
    input  logic [CW-1:0] i_wire_c1p,
    input  logic [CW-1:0] i_wire_sa,
    input  logic [CW-1:0] i_wire_c2,
    output logic [CW-1:0] o_wire_sat
);

    localparam logic [CW-1:0] MAX = '1;

    function automatic logic [CW-1:0] nmul(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y
    );
        return CW'(mul_norm(32'(x), 32'(y), CW));
    endfunction

    logic [CW:0] sum_d;
    logic [CW:0] sum_q;

    always_comb begin
        sum_d = '0;
        unique case (i_wire_mode)
            BLEND_OVER:
                sum_d = {1'b0, nmul(i_wire_c1p, i_wire_sa)}
                      + {1'b0, nmul(i_wire_c2, MAX - i_wire_sa)};
            BLEND_MULTIPLY:
                sum_d = {1'b0, nmul(i_wire_c1p, i_wire_c2)};
            BLEND_ADD:
                sum_d = {1'b0, i_wire_c2}
                      + {1'b0, nmul(i_wire_c1p, i_wire_sa)};
            default:
                sum_d = '0;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            sum_q <= '0;
        end else if (i_wire_en) begin
            sum_q <= sum_d;
        end
    end

    assign o_wire_sat = sum_q[CW] ? MAX : sum_q[CW-1:0];

endmodule

// File: rtl/painterengine_gpu_blend_pipe.sv
// Joins source/destination pixel streams and blends them in a 3-stage stallable pipe.
// Ports: i_wire_clock, i_wire_resetn, bus (slave). Option: PAINTERENGINE_GPU_BLEND_SKID_EN.
module painterengine_gpu_blend_pipe
    import painterengine_gpu_pkg::*;
#(
    parameter int CW           = 8,
    parameter int ORDER_SEL_EN = 1
) (
    input  logic                           i_wire_clock,
    input  logic                           i_wire_resetn,
    painterengine_gpu_blend_pipe_if.slave  bus
);

    localparam int PW = 4 * CW;
    localparam logic [CW-1:0] MAX = '1;

    function automatic logic [CW-1:0] nmul(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y
    );
        return CW'(mul_norm(32'(x), 32'(y), CW));
    endfunction

    logic en;
    logic accept;
    logic v1, v2, v3;
    logic order_in;

    // Channel index 0 = A, 1 = R, 2 = G, 3 = B.
    logic [CW-1:0] src_ch [4];
    logic [CW-1:0] dst_ch [4];
    logic [CW-1:0] bl_ch  [4];

    assign accept = bus.i_wire_valid1 & bus.i_wire_valid2 & en;
    assign bus.o_wire_ready1 = bus.i_wire_valid2 & en;
    assign bus.o_wire_ready2 = bus.i_wire_valid1 & en;
    assign order_in = (ORDER_SEL_EN != 0) ? bus.i_wire_argb_mode
                                          : BLENDER_ARGB_MODE_AXXX;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (order_in == BLENDER_ARGB_MODE_AXXX) begin
                src_ch[i] = bus.i_wire_data1_in[(3-i)*CW +: CW];
                dst_ch[i] = bus.i_wire_data2_in[(3-i)*CW +: CW];
            end else begin
                src_ch[i] = bus.i_wire_data1_in[i*CW +: CW];
                dst_ch[i] = bus.i_wire_data2_in[i*CW +: CW];
            end
            bl_ch[i] = bus.i_wire_blend[(3-i)*CW +: CW];
        end
    end

    // Stage 1: blend-colour scaling.
    logic [CW-1:0] s1_sa, s1_a1, s1_a2;
    logic [CW-1:0] s1_c1p [3];
    logic [CW-1:0] s1_c2  [3];
    blend_mode_t   s1_mode;
    logic          s1_order;
    logic [PW-1:0] s1_raw;

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            v1       <= 1'b0;
            s1_sa    <= '0;
            s1_a1    <= '0;
            s1_a2    <= '0;
            s1_mode  <= BLEND_OVER;
            s1_order <= 1'b0;
            s1_raw   <= '0;
            for (int j = 0; j < 3; j++) begin
                s1_c1p[j] <= '0;
                s1_c2[j]  <= '0;
            end
        end else if (en) begin
            v1 <= accept;
            if (accept) begin
                s1_sa    <= nmul(src_ch[0], bl_ch[0]);
                s1_a1    <= src_ch[0];
                s1_a2    <= dst_ch[0];
                s1_mode  <= blend_mode_t'(bus.i_wire_mode);
                s1_order <= order_in;
                s1_raw   <= bus.i_wire_data1_in;
                for (int j = 0; j < 3; j++) begin
                    s1_c1p[j] <= nmul(src_ch[j+1], bl_ch[j+1]);
                    s1_c2[j]  <= dst_ch[j+1];
                end
            end
        end
    end

    // Stage 2: colour lanes plus inline alpha.
    logic [CW-1:0] lane_sat [3];
    logic [CW:0]   a_sum_d;
    logic [CW:0]   s2_asum;
    logic          s2_copy;
    logic          s2_order;
    logic [PW-1:0] s2_raw;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        painterengine_gpu_blend_lane #(.CW(CW)) u_lane (
            .i_wire_clock  (i_wire_clock),
            .i_wire_resetn (i_wire_resetn),
            .i_wire_en     (en),
            .i_wire_mode   (s1_mode),
            .i_wire_c1p    (s1_c1p[g]),
            .i_wire_sa     (s1_sa),
            .i_wire_c2     (s1_c2[g]),
            .o_wire_sat    (lane_sat[g])
        );
    end

    always_comb begin
        a_sum_d = '0;
        unique case (s1_mode)
            BLEND_OVER:
                a_sum_d = {1'b0, s1_sa} + {1'b0, nmul(s1_a2, MAX - s1_sa)};
            BLEND_MULTIPLY:
                a_sum_d = {1'b0, nmul(s1_a1, s1_a2)};
            BLEND_ADD:
                a_sum_d = {1'b0, s1_a2} + {1'b0, s1_sa};
            default:
                a_sum_d = '0;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            v2       <= 1'b0;
            s2_asum  <= '0;
            s2_copy  <= 1'b0;
            s2_order <= 1'b0;
            s2_raw   <= '0;
        end else if (en) begin
            v2       <= v1;
            s2_asum  <= a_sum_d;
            s2_copy  <= (s1_mode == BLEND_COPY);
            s2_order <= s1_order;
            s2_raw   <= s1_raw;
        end
    end

    // Stage 3: saturate and repack in the pixel's own order.
    logic [CW-1:0] a_sat;
    logic [PW-1:0] packed_px;
    logic [PW-1:0] s3_data;

    assign a_sat = s2_asum[CW] ? MAX : s2_asum[CW-1:0];
    assign packed_px = (s2_order == BLENDER_ARGB_MODE_AXXX)
        ? {a_sat, lane_sat[0], lane_sat[1], lane_sat[2]}
        : {lane_sat[2], lane_sat[1], lane_sat[0], a_sat};

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            v3      <= 1'b0;
            s3_data <= '0;
        end else if (en) begin
            v3      <= v2;
            s3_data <= s2_copy ? s2_raw : packed_px;
        end
    end

`ifdef PAINTERENGINE_GPU_BLEND_SKID_EN
    // 2-entry skid: stage 3 drains into it whenever it has room, so the
    // input readies never see i_wire_out_ready combinationally.
    logic [PW-1:0] sk_mem [2];
    logic          sk_wp, sk_rp;
    logic [1:0]    sk_cnt;
    logic          sk_push, sk_pop;

    assign en      = (sk_cnt != 2'd2);
    assign sk_push = v3 & en;
    assign sk_pop  = (sk_cnt != 2'd0) & bus.i_wire_out_ready;

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            sk_wp     <= 1'b0;
            sk_rp     <= 1'b0;
            sk_cnt    <= 2'd0;
            sk_mem[0] <= '0;
            sk_mem[1] <= '0;
        end else begin
            if (sk_push) begin
                sk_mem[sk_wp] <= s3_data;
                sk_wp         <= ~sk_wp;
            end
            if (sk_pop) begin
                sk_rp <= ~sk_rp;
            end
            sk_cnt <= sk_cnt + {1'b0, sk_push} - {1'b0, sk_pop};
        end
    end

    assign bus.o_wire_data_valid = (sk_cnt != 2'd0);
    assign bus.o_wire_data_out   = sk_mem[sk_rp];
`else
    assign en = ~v3 | bus.i_wire_out_ready;
    assign bus.o_wire_data_valid = v3;
    assign bus.o_wire_data_out   = s3_data;
`endif

endmodule

// File: tb/tb_painterengine_gpu_blend_pipe.sv
// Directed self-checking bench for painterengine_gpu_blend_pipe (CW = 8).
// Covers blend modes, channel order, join, backpressure and async reset.
module tb_painterengine_gpu_blend_pipe;

`ifdef PAINTERENGINE_GPU_BLEND_SKID_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    painterengine_gpu_blend_pipe_if #(.CW(8)) bus ();

    painterengine_gpu_blend_pipe #(.CW(8), .ORDER_SEL_EN(1)) dut (
        .i_wire_clock  (clk),
        .i_wire_resetn (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [1:0] mode,
                           input logic order, input logic [31:0] blend,
                           input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] exp);
        int n;
        @(negedge clk);
        bus.i_wire_mode      = mode;
        bus.i_wire_argb_mode = order;
        bus.i_wire_blend     = blend;
        bus.i_wire_data1_in  = src;
        bus.i_wire_data2_in  = dst;
        bus.i_wire_valid1    = 1'b1;
        bus.i_wire_valid2    = 1'b1;
        bus.i_wire_out_ready = 1'b1;
        @(negedge clk);
        bus.i_wire_valid1 = 1'b0;
        bus.i_wire_valid2 = 1'b0;
        n = 1;
        while (!bus.o_wire_data_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_data"}, bus.o_wire_data_out, exp);
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
    endtask

    initial begin
        int n;
        int sent;
        int got;
        logic stall_prev;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_wire_argb_mode = 1'b1;
        bus.i_wire_mode      = 2'd0;
        bus.i_wire_blend     = '0;
        bus.i_wire_data1_in  = '0;
        bus.i_wire_data2_in  = '0;
        bus.i_wire_valid1    = 1'b0;
        bus.i_wire_valid2    = 1'b0;
        bus.i_wire_out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(bus.o_wire_data_valid), 32'd0);
        chk("rst_data", bus.o_wire_data_out, 32'd0);
        chk("rst_ready1", 32'(bus.o_wire_ready1), 32'd0);
        chk("rst_ready2", 32'(bus.o_wire_ready2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("over_argb", 2'd0, 1'b1, 32'hFFFFFFFF,
                32'h80FF0000, 32'hFF0000FF, 32'hFF80007F);
        run_one("multiply", 2'd1, 1'b1, 32'hFFFFFFFF,
                32'hFF808080, 32'hFF808080, 32'hFF404040);
        run_one("copy", 2'd3, 1'b1, 32'hFFFFFFFF,
                32'h12345678, 32'h00000000, 32'h12345678);
        run_one("add_sat", 2'd2, 1'b1, 32'hFFFFFFFF,
                32'hFFC0C0C0, 32'hFF808080, 32'hFFFFFFFF);
        run_one("add_blend0", 2'd2, 1'b1, 32'hFF000000,
                32'hFFC0C0C0, 32'hFF808080, 32'hFF808080);
        run_one("over_bgra", 2'd0, 1'b0, 32'hFFFFFFFF,
                32'h0000FF80, 32'hFF0000FF, 32'h7F0080FF);

        // Only the source is valid: nothing may transfer.
        @(negedge clk);
        bus.i_wire_argb_mode = 1'b1;
        bus.i_wire_mode      = 2'd3;
        bus.i_wire_data1_in  = 32'h11223344;
        bus.i_wire_valid1    = 1'b1;
        bus.i_wire_valid2    = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("join_ready1", 32'(bus.o_wire_ready1), 32'd0);
            chk("join_ready2", 32'(bus.o_wire_ready2), 32'd1);
            chk("join_noout", 32'(bus.o_wire_data_valid), 32'd0);
            @(negedge clk);
        end
        bus.i_wire_valid2 = 1'b1;
        #1;
        chk("join_both", 32'(bus.o_wire_ready1 & bus.o_wire_ready2), 32'd1);
        @(negedge clk);
        bus.i_wire_valid1 = 1'b0;
        bus.i_wire_valid2 = 1'b0;
        n = 1;
        while (!bus.o_wire_data_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("join_data", bus.o_wire_data_out, 32'h11223344);
        @(negedge clk);
        chk("join_single", 32'(bus.o_wire_data_valid), 32'd0);

        // 10 pixels with out_ready cycling 1,0,0,1.
        sent = 0;
        got = 0;
        stall_prev = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            @(negedge clk);
            bus.i_wire_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.i_wire_valid1    = (sent < 10);
            bus.i_wire_valid2    = (sent < 10);
            bus.i_wire_data1_in  = 32'hC0DE0000 + 32'(sent);
            bus.i_wire_data2_in  = ~(32'hC0DE0000 + 32'(sent));
            #1;
            if (stall_prev)
                chk("stall_valid", 32'(bus.o_wire_data_valid), 32'd1);
            if (bus.o_wire_data_valid)
                chk("stream_data", bus.o_wire_data_out,
                    32'hC0DE0000 + 32'(got));
            stall_prev = bus.o_wire_data_valid & ~bus.i_wire_out_ready;
            if (bus.i_wire_valid1 & bus.o_wire_ready1)
                sent++;
            if (bus.o_wire_data_valid & bus.i_wire_out_ready)
                got++;
        end
        chk("stream_sent", 32'(sent), 32'd10);
        chk("stream_got", 32'(got), 32'd10);
        @(negedge clk);
        bus.i_wire_valid1    = 1'b0;
        bus.i_wire_valid2    = 1'b0;
        bus.i_wire_out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("stream_nodup", 32'(bus.o_wire_data_valid), 32'd0);

        // Fill the pipe while stalled, then reset mid-stream.
        @(negedge clk);
        bus.i_wire_out_ready = 1'b0;
        bus.i_wire_mode      = 2'd3;
        bus.i_wire_data1_in  = 32'hDEAD0001;
        bus.i_wire_valid1    = 1'b1;
        bus.i_wire_valid2    = 1'b1;
        repeat (LAT) @(negedge clk);
        bus.i_wire_valid1 = 1'b0;
        bus.i_wire_valid2 = 1'b0;
        chk("inflight_valid", 32'(bus.o_wire_data_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.o_wire_data_valid), 32'd0);
        chk("async_rst_data", bus.o_wire_data_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one("post_reset", 2'd3, 1'b1, 32'hFFFFFFFF,
                32'h0BADF00D, 32'h00000000, 32'h0BADF00D);
        @(negedge clk);
        chk("post_reset_empty", 32'(bus.o_wire_data_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
